// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings and defaults for the load/store front-end.
//   SZ_WORD/SZ_HALF/SZ_BYTE : request size encodings (2'b11 reserved, treated as word)
//   state_t                 : 2-bit FSM state encoding
//   BASE_DEFAULT/DEPTH_DEFAULT : data memory window defaults
//   req_ctx_t               : request fields held across the multi-cycle access
package mem_access_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [31:0]  BASE_DEFAULT  = 32'h1001_0000;
  localparam int unsigned  DEPTH_DEFAULT = 512;

  // Only the low address bits and low store bits are needed after capture.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  lane;
    logic [15:0] wdata_lo;
  } req_ctx_t;

  // Reserved encoding behaves as a full word.
  function automatic logic size_is_word(input logic [1:0] size);
    return (size != SZ_HALF) && (size != SZ_BYTE);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_HALF) return lane[0];
    if (size == SZ_BYTE) return 1'b0;
    return lane != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and data memory signals of the
// load/store front-end.
//   CPU side   : req, we, size, sext, addr, wdata -> ready, rdata, addr_err
//   memory side: mem_ena, mem_wena, mem_addr, mem_wdata -> mem_rdata
//   modport master : CPU plus memory (drives requests, returns mem_rdata)
//   modport slave  : the front-end itself
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        addr_err;
  logic        mem_ena;
  logic        mem_wena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req, we, size, sext, addr, wdata, mem_rdata,
    input  ready, rdata, addr_err, mem_ena, mem_wena, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_rdata,
    output ready, rdata, addr_err, mem_ena, mem_wena, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane handling for the load/store front-end.
//   i_size, i_sext, i_lane : captured request size, extension mode, addr[1:0]
//   i_rdata                : word read from memory
//   i_wdata                : low 16 bits of the store data
//   o_load_c               : extracted and sign/zero-extended load result
//   o_merge_c              : i_rdata with the addressed lane replaced by store data
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_c,
  output logic [31:0] o_merge_c
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  // Little-endian: byte lane n lives at bits [8n+7:8n], half lane at [16n+15:16n].
  always_comb begin
    w_byte_sh   = {i_lane, 3'b000};
    w_half_sh   = {i_lane[1], 4'b0000};
    w_byte      = 8'(i_rdata >> w_byte_sh);
    w_half      = 16'(i_rdata >> w_half_sh);
    w_byte_mask = 32'h0000_00FF << w_byte_sh;
    w_half_mask = 32'h0000_FFFF << w_half_sh;
    o_load_c    = i_rdata;
    o_merge_c   = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_load_c  = {{24{i_sext & w_byte[7]}}, w_byte};
        o_merge_c = (i_rdata & ~w_byte_mask) |
                    ((32'(i_wdata[7:0]) << w_byte_sh) & w_byte_mask);
      end
      SZ_HALF: begin
        o_load_c  = {{16{i_sext & w_half[15]}}, w_half};
        o_merge_c = (i_rdata & ~w_half_mask) |
                    ((32'(i_wdata) << w_half_sh) & w_half_mask);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end in front of the word-wide data memory.
// Turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into word-aligned accesses, with
// read-modify-write for sub-word stores and an alignment check.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_access_unit_if.slave (CPU request/response + memory port)
// Build option: define MEM_RANGE_CHK_EN to also flag addresses outside
// [BASE, BASE+4*DEPTH) as errors without touching memory.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [31:0] BASE  = BASE_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  state_t      r_state;
  req_ctx_t    r_ctx;
  logic        r_ready;
  logic        r_addr_err;
  logic        r_mem_ena;
  logic        r_mem_wena;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_range_err;
  logic        w_req_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;

`ifdef MEM_RANGE_CHK_EN
  localparam logic [32:0] LIMIT = 33'(BASE) + (33'(DEPTH) << 2);
  assign w_range_err = (bus.addr < BASE) || (33'(bus.addr) >= LIMIT);
`else
  // Window parameters only matter when the range check is built in.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{BASE, DEPTH};
  assign w_range_err  = 1'b0;
`endif

  assign w_req_err = misaligned(bus.size, bus.addr[1:0]) | w_range_err;

  mem_lane_align u_align (
    .i_size    (r_ctx.size),
    .i_sext    (r_ctx.sext),
    .i_lane    (r_ctx.lane),
    .i_rdata   (bus.mem_rdata),
    .i_wdata   (r_ctx.wdata_lo),
    .o_load_c  (w_load),
    .o_merge_c (w_merge)
  );

  // Request FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ctx       <= '0;
      r_ready     <= 1'b0;
      r_addr_err  <= 1'b0;
      r_mem_ena   <= 1'b0;
      r_mem_wena  <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        // DONE accepts a held request directly so back-to-back ops lose no cycle.
        ST_IDLE, ST_DONE: begin
          r_mem_ena  <= 1'b0;
          r_mem_wena <= 1'b0;
          r_addr_err <= 1'b0;
          if (bus.req) begin
            r_ctx       <= '{we: bus.we, size: bus.size, sext: bus.sext,
                             lane: bus.addr[1:0], wdata_lo: bus.wdata[15:0]};
            r_mem_addr  <= {bus.addr[31:2], 2'b00};
            r_mem_wdata <= bus.wdata;
            if (w_req_err) begin
              r_addr_err <= 1'b1;
              r_rdata    <= '0;
              r_ready    <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_mem_ena  <= 1'b1;
              r_mem_wena <= bus.we & size_is_word(bus.size);
              r_state    <= ST_ACCESS;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (r_ctx.we && !size_is_word(r_ctx.size)) begin
            // Sub-word store: fold the new lane into the word just read.
            r_mem_wdata <= w_merge;
            r_mem_ena   <= 1'b1;
            r_mem_wena  <= 1'b1;
            r_state     <= ST_WRITE;
          end else begin
            r_rdata    <= r_ctx.we ? 32'h0 : w_load;
            r_mem_ena  <= 1'b0;
            r_mem_wena <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_WRITE: begin
          r_rdata    <= '0;
          r_mem_ena  <= 1'b0;
          r_mem_wena <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.rdata     = r_rdata;
  assign bus.addr_err  = r_addr_err;
  assign bus.mem_ena   = r_mem_ena;
  assign bus.mem_wena  = r_mem_wena;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit. A word-wide
// memory model answers the DUT; a byte-addressed reference model predicts
// load results, errors, latency and the final memory image.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam logic [31:0] BASE      = 32'h1001_0000;
  localparam int          WIN_BYTES = 2048;
  localparam int          NV        = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus_if();

  mem_access_unit #(.BASE(BASE), .DEPTH(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Word memory driven by the DUT: combinational read, negedge write.
  logic [31:0] phys [0:511];
  bit          phys_init_done = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] rd_off;
  logic [31:0] wr_off;

  assign rd_off = bus_if.mem_addr - BASE;
  assign bus_if.mem_rdata = (rd_off < 32'(WIN_BYTES)) ? phys[rd_off[10:2]] : 32'h0;

  always @(negedge clk) begin
    if (!phys_init_done) begin
      for (int i = 0; i < 512; i++) phys[i] = 32'h0;
      phys[1] = 32'h8899_AABB;
      phys_init_done = 1'b1;
    end else if (bus_if.mem_ena && bus_if.mem_wena) begin
      wr_count++;
      last_wdata = bus_if.mem_wdata;
      wr_off = bus_if.mem_addr - BASE;
      if (wr_off < 32'(WIN_BYTES)) phys[wr_off[10:2]] = bus_if.mem_wdata;
    end
  end

  // Reference model: byte-addressed memory window.
  byte unsigned mb [0:2047];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] model_word(input int off);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(mb[off + k]) << (8 * k));
    return w;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return (a - BASE) < 32'(WIN_BYTES);
  endfunction

  task automatic model_req(input bit we, input logic [1:0] sz, input bit sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output bit err, output int lat,
                           output int enac, output int wrs);
    int     n;
    int     off;
    bit     inwin;
    longint val;
    n     = (sz == 2'b01) ? 2 : ((sz == 2'b10) ? 1 : 4);
    err   = (a % 32'(n)) != 32'h0;
    inwin = in_window(a);
    off   = int'(a - BASE);
`ifdef MEM_RANGE_CHK_EN
    if (!inwin) err = 1'b1;
`endif
    rd = '0; lat = 1; enac = 0; wrs = 0;
    if (err) return;
    if (!we) begin
      val = 0;
      for (int k = 0; k < n; k++)
        if (inwin) val += longint'(mb[off + k]) << (8 * k);
      if (sx && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
      rd   = 32'(val);
      lat  = 2;
      enac = 1;
    end else begin
      for (int k = 0; k < n; k++)
        if (inwin) mb[off + k] = 8'(wd >> (8 * k));
      lat  = (n == 4) ? 2 : 3;
      enac = (n == 4) ? 1 : 2;
      wrs  = 1;
    end
  endtask

  // Issue one request and wait (bounded) for ready; hold keeps req high after ready.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd, output bit err, output int lat,
                        output int enac, output int wrs, output logic [31:0] lastw);
    int w0;
    bit done;
    bus_if.we = we; bus_if.size = sz; bus_if.sext = sx;
    bus_if.addr = a; bus_if.wdata = wd; bus_if.req = 1'b1;
    w0 = wr_count; lat = 0; enac = 0; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus_if.ready) begin
        done = 1'b1;
        rd   = bus_if.rdata;
        err  = bus_if.addr_err;
        if (!hold) bus_if.req = 1'b0;
      end else if (bus_if.mem_ena) begin
        enac++;
      end
    end
    if (!done) begin
      $display("FAIL timeout: no ready within %0d cycles, addr 0x%08h", lat, a);
      n_checks++;
      bus_if.req = 1'b0;
    end
    wrs   = wr_count - w0;
    lastw = last_wdata;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          chk_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_ena;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, lastw, m_rd, a, wd;
    bit          err, m_err, we, sx;
    logic [1:0]  sz;
    int          lat, enac, wrs, m_lat, m_ena, m_wrs, w0;

    for (int i = 0; i < 2048; i++) mb[i] = 8'h00;
    mb[4] = 8'hBB; mb[5] = 8'hAA; mb[6] = 8'h99; mb[7] = 8'h88;

    //            we  sz     sx  addr          wdata          exp_rd        chk err lat ena wr exp_wdata
    vt[0]  = '{1'b0, 2'b10, 1'b1, 32'h1001_0005, 32'h0,        32'hFFFF_FFAA, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[1]  = '{1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0,        32'h0000_8899, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[2]  = '{1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0,        32'hFFFF_8899, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0,        32'h0000_00BB, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[4]  = '{1'b1, 2'b10, 1'b0, 32'h1001_0007, 32'h0000_00CC, 32'h0,        1'b0, 1'b0, 3, 2, 1, 32'hCC99_AABB};
    vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h1001_0004, 32'h0,        32'hCC99_AABB, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[6]  = '{1'b0, 2'b00, 1'b0, 32'h1001_0002, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0, 32'h0};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h1001_0003, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0, 32'h0};
    vt[8]  = '{1'b0, 2'b11, 1'b1, 32'h1001_0004, 32'h0,        32'hCC99_AABB, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h1001_0008, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 2, 1, 1, 32'h1234_5678};
    vt[10] = '{1'b1, 2'b01, 1'b0, 32'h1001_000A, 32'hFFFF_ABCD, 32'h0,        1'b0, 1'b0, 3, 2, 1, 32'hABCD_5678};
    vt[11] = '{1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0,        32'hABCD_5678, 1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[12] = '{1'b1, 2'b10, 1'b1, 32'h1001_0009, 32'h0000_0011, 32'h0,        1'b0, 1'b0, 3, 2, 1, 32'hABCD_1178};
    vt[13] = '{1'b0, 2'b10, 1'b1, 32'h1001_0009, 32'h0,        32'h0000_0011, 1'b1, 1'b0, 2, 1, 0, 32'h0};
`ifdef MEM_RANGE_CHK_EN
    vt[14] = '{1'b0, 2'b00, 1'b0, 32'h1001_0800, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0, 32'h0};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h1000_FFFC, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0, 32'h0};
`else
    vt[14] = '{1'b0, 2'b00, 1'b0, 32'h1001_0800, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0, 32'h0};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h1000_FFFC, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0, 32'h0};
`endif

    // Reset state.
    rst_n = 1'b0;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.size = 2'b00; bus_if.sext = 1'b0;
    bus_if.addr = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus_if.ready), 32'h0);
    check("rst_addr_err", 32'(bus_if.addr_err), 32'h0);
    check("rst_mem_ena", 32'(bus_if.mem_ena), 32'h0);
    check("rst_mem_wena", 32'(bus_if.mem_wena), 32'h0);
    check("rst_rdata", bus_if.rdata, 32'h0);
    check("rst_mem_addr", bus_if.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].we, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, 1'b0, rd, err, lat, enac, wrs, lastw);
      model_req(vt[i].we, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, m_rd, m_err, m_lat, m_ena, m_wrs);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("vec%0d_ena_cycles", i), 32'(enac), 32'(vt[i].exp_ena));
      check($sformatf("vec%0d_writes", i), 32'(wrs), 32'(vt[i].exp_wr));
      if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      if (vt[i].exp_wr != 0) check($sformatf("vec%0d_wdata", i), lastw, vt[i].exp_wdata);
      @(posedge clk); #1;
    end

    // sb cycle by cycle: read phase, then merged write.
    bus_if.we = 1'b1; bus_if.size = SZ_BYTE; bus_if.sext = 1'b0;
    bus_if.addr = 32'h1001_0012; bus_if.wdata = 32'hFFFF_FF5A; bus_if.req = 1'b1;
    @(posedge clk); #1;
    check("sb_access_ena", 32'(bus_if.mem_ena), 32'h1);
    check("sb_access_wena", 32'(bus_if.mem_wena), 32'h0);
    check("sb_access_mem_addr", bus_if.mem_addr, 32'h1001_0010);
    @(posedge clk); #1;
    check("sb_write_wena", 32'(bus_if.mem_wena), 32'h1);
    check("sb_write_wdata", bus_if.mem_wdata, 32'h005A_0000);
    check("sb_write_ready", 32'(bus_if.ready), 32'h0);
    @(posedge clk); #1;
    check("sb_done_ready", 32'(bus_if.ready), 32'h1);
    bus_if.req = 1'b0;
    model_req(1'b1, SZ_BYTE, 1'b0, 32'h1001_0012, 32'hFFFF_FF5A, m_rd, m_err, m_lat, m_ena, m_wrs);
    @(posedge clk); #1;

    // Back-to-back: req held through DONE starts the next access immediately.
    model_req(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, m_rd, m_err, m_lat, m_ena, m_wrs);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 1'b1, rd, err, lat, enac, wrs, lastw);
    check("b2b_first_rdata", rd, m_rd);
    check("b2b_first_lat", 32'(lat), 32'd2);
    bus_if.size = SZ_BYTE; bus_if.sext = 1'b1; bus_if.addr = 32'h1001_0005;
    model_req(1'b0, SZ_BYTE, 1'b1, 32'h1001_0005, 32'h0, m_rd, m_err, m_lat, m_ena, m_wrs);
    @(posedge clk); #1;
    check("b2b_no_idle_ena", 32'(bus_if.mem_ena), 32'h1);
    check("b2b_no_idle_ready", 32'(bus_if.ready), 32'h0);
    @(posedge clk); #1;
    check("b2b_second_ready", 32'(bus_if.ready), 32'h1);
    check("b2b_second_rdata", bus_if.rdata, m_rd);
    bus_if.req = 1'b0;
    @(posedge clk); #1;

    // Reset during the write phase of an sh.
    bus_if.we = 1'b1; bus_if.size = SZ_HALF; bus_if.sext = 1'b0;
    bus_if.addr = 32'h1001_0016; bus_if.wdata = 32'h0000_BEEF; bus_if.req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw_write_phase", 32'(bus_if.mem_wena), 32'h1);
    rst_n = 1'b0;
    w0 = wr_count;
    @(posedge clk); #1;
    check("rstw_ready", 32'(bus_if.ready), 32'h0);
    check("rstw_mem_ena", 32'(bus_if.mem_ena), 32'h0);
    check("rstw_mem_wena", 32'(bus_if.mem_wena), 32'h0);
    check("rstw_rdata", bus_if.rdata, 32'h0);
    check("rstw_addr_err", 32'(bus_if.addr_err), 32'h0);
    check("rstw_mem_addr", bus_if.mem_addr, 32'h0);
    check("rstw_mem_wdata", bus_if.mem_wdata, 32'h0);
    bus_if.req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_no_ready", 32'(bus_if.ready), 32'h0);
    check("rstw_write_count", 32'(wr_count - w0), 32'd1);
    model_req(1'b1, SZ_HALF, 1'b0, 32'h1001_0016, 32'h0000_BEEF, m_rd, m_err, m_lat, m_ena, m_wrs);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_req(1'b0, SZ_WORD, 1'b0, 32'h1001_0014, 32'h0, m_rd, m_err, m_lat, m_ena, m_wrs);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h1001_0014, 32'h0, 1'b0, rd, err, lat, enac, wrs, lastw);
    check("rstw_readback", rd, m_rd);
    check("rstw_readback_lat", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Randomized requests against the reference model.
    for (int it = 0; it < 300; it++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) a = $urandom();
      else a = BASE + 32'($urandom_range(0, 63));
      wd = $urandom();
      model_req(we, sz, sx, a, wd, m_rd, m_err, m_lat, m_ena, m_wrs);
      do_req(we, sz, sx, a, wd, 1'b0, rd, err, lat, enac, wrs, lastw);
      check($sformatf("rnd%0d_err a=%08h", it, a), 32'(err), 32'(m_err));
      check($sformatf("rnd%0d_lat", it), 32'(lat), 32'(m_lat));
      check($sformatf("rnd%0d_ena_cycles", it), 32'(enac), 32'(m_ena));
      check($sformatf("rnd%0d_writes", it), 32'(wrs), 32'(m_wrs));
      if (!we || m_err) check($sformatf("rnd%0d_rdata", it), rd, m_rd);
      if (we && !m_err && in_window(a))
        check($sformatf("rnd%0d_wdata", it), lastw, model_word(int'((a - BASE) & 32'hFFFF_FFFC)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    // Final memory image versus the byte model.
    w0 = 0;
    for (int i = 0; i < 512; i++)
      if (phys[i] !== model_word(4 * i)) w0++;
    check("mem_image_mismatching_words", 32'(w0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
